// File: rtl/dsp_pkg.sv
// Shared widths and M-register types for the DSP multiplier datapath.
package dsp_pkg;

  localparam int AW     = 25;
  localparam int BW     = 18;
  localparam int PW     = 43;
  localparam int BSPLIT = 9;

  typedef logic signed [PW-1:0] prod_t;

  typedef struct packed {
    prod_t mx;
    prod_t my;
    logic  valid;
  } mreg_t;

endpackage

// File: rtl/mult_pp25x18.sv
// Combinational 25x18 signed partial-product generator.
// B is split so that pp_lo + pp_hi is the exact product.
module mult_pp25x18
  import dsp_pkg::*;
(
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic          use_mult,
  output prod_t         pp_lo,
  output prod_t         pp_hi
);

  prod_t a_x;
  prod_t blo_x;
  prod_t bhi_x;

  // Low slice is unsigned; the high slice carries B's sign.
  always_comb begin
    a_x   = {{(PW-AW){a[AW-1]}}, a};
    blo_x = {{(PW-BSPLIT){1'b0}}, b[BSPLIT-1:0]};
    bhi_x = {{(PW-BW+BSPLIT){b[BW-1]}},
             b[BW-1:BSPLIT]};
    pp_lo = '0;
    pp_hi = '0;
    if (use_mult) begin
      pp_lo = a_x * blo_x;
      pp_hi = (a_x * bhi_x) <<< BSPLIT;
    end
  end

endmodule

// File: rtl/mult_stage.sv
// Multiplier stage with optional M register and valid tracking.
// MULT_FUSED_OUT_EN: sum partials before the M register (M_Y = 0).
module mult_stage
  import dsp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          CEM,
  input  logic          MREG,
  input  logic          USE_MULT,
  input  logic          IN_VALID,
  input  logic [AW-1:0] A_MULT,
  input  logic [BW-1:0] B_MULT,
  output logic [PW-1:0] M_X,
  output logic [PW-1:0] M_Y,
  output logic          M_VALID,
  output logic          MULTSIGNOUT
);

  prod_t pp_lo;
  prod_t pp_hi;
  prod_t pp_x;
  prod_t pp_y;
  mreg_t m_d;
  mreg_t m_q;

  mult_pp25x18 u_pp (
    .a        (A_MULT),
    .b        (B_MULT),
    .use_mult (USE_MULT),
    .pp_lo    (pp_lo),
    .pp_hi    (pp_hi)
  );

  always_comb begin
`ifdef MULT_FUSED_OUT_EN
    pp_x = pp_lo + pp_hi;
    pp_y = '0;
`else
    pp_x = pp_lo;
    pp_y = pp_hi;
`endif
  end

  always_comb begin
    m_d = m_q;
    if (CEM) begin
      m_d.mx    = pp_x;
      m_d.my    = pp_y;
      m_d.valid = IN_VALID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) m_q <= '0;
    else     m_q <= m_d;
  end

  // Bypass still lets the register track CEM underneath.
  always_comb begin
    if (MREG) begin
      M_X     = m_q.mx;
      M_Y     = m_q.my;
      M_VALID = m_q.valid;
    end else begin
      M_X     = pp_x;
      M_Y     = pp_y;
      M_VALID = IN_VALID;
    end
  end

  assign MULTSIGNOUT = 1'((M_X + M_Y) >> (PW-1));

endmodule

// File: tb/tb_mult_stage.sv
// Directed self-checking bench for mult_stage.
module tb_mult_stage;

  logic               clk = 1'b0;
  logic               rst;
  logic               CEM;
  logic               MREG;
  logic               USE_MULT;
  logic               IN_VALID;
  logic        [24:0] A_MULT;
  logic        [17:0] B_MULT;
  logic signed [42:0] M_X;
  logic signed [42:0] M_Y;
  logic               M_VALID;
  logic               MULTSIGNOUT;
  logic signed [42:0] sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign sum = M_X + M_Y;

  mult_stage dut (
    .clk         (clk),
    .rst         (rst),
    .CEM         (CEM),
    .MREG        (MREG),
    .USE_MULT    (USE_MULT),
    .IN_VALID    (IN_VALID),
    .A_MULT      (A_MULT),
    .B_MULT      (B_MULT),
    .M_X         (M_X),
    .M_Y         (M_Y),
    .M_VALID     (M_VALID),
    .MULTSIGNOUT (MULTSIGNOUT)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; CEM = 1'b1; MREG = 1'b1;
    USE_MULT = 1'b1; IN_VALID = 1'b1;
    A_MULT = 25'd12; B_MULT = 18'd34;
    tick();
    tests++;
    if (M_X !== 43'sd0) begin
      fails++; $display("FAIL reset_mx got %0d want 0", M_X);
    end
    tests++;
    if (M_Y !== 43'sd0) begin
      fails++; $display("FAIL reset_my got %0d want 0", M_Y);
    end
    tests++;
    if (M_VALID !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %b want 0", M_VALID);
    end
    tests++;
    if (MULTSIGNOUT !== 1'b0) begin
      fails++; $display("FAIL reset_sign got %b want 0", MULTSIGNOUT);
    end
    rst = 1'b0;
  endtask

  task automatic test_neg_one();
    A_MULT = 25'h1FFFFFF; B_MULT = 18'h3FFFF; IN_VALID = 1'b1;
    tick();
    tests++;
    if (sum !== 43'sd1 || M_VALID !== 1'b1 || MULTSIGNOUT !== 1'b0) begin
      fails++;
      $display("FAIL neg_one got sum=%0d v=%b s=%b want 1 1 0",
               sum, M_VALID, MULTSIGNOUT);
    end
    tests++;
`ifdef MULT_FUSED_OUT_EN
    if (M_X !== 43'sd1 || M_Y !== 43'sd0) begin
      fails++;
      $display("FAIL neg_one_split got %0d/%0d want 1/0", M_X, M_Y);
    end
`else
    if (M_X !== -43'sd511 || M_Y !== 43'sd512) begin
      fails++;
      $display("FAIL neg_one_split got %0d/%0d want -511/512", M_X, M_Y);
    end
`endif
  endtask

  task automatic test_extremes();
    A_MULT = 25'h0FFFFFF; B_MULT = 18'h1FFFF;
    tick();
    tests++;
    if (sum !== 43'sd2199006347265 || MULTSIGNOUT !== 1'b0) begin
      fails++;
      $display("FAIL max_max got %0d s=%b want 2199006347265 0",
               sum, MULTSIGNOUT);
    end
    A_MULT = 25'h1000000; B_MULT = 18'h20000;
    tick();
    tests++;
    if (sum !== 43'sh200_0000_0000 || MULTSIGNOUT !== 1'b0) begin
      fails++;
      $display("FAIL min_min got %h s=%b want 20000000000 0",
               sum, MULTSIGNOUT);
    end
    A_MULT = 25'h1000000; B_MULT = 18'h1FFFF;
    tick();
    tests++;
    if (sum !== -43'sd2199006478336 || MULTSIGNOUT !== 1'b1) begin
      fails++;
      $display("FAIL min_max got %0d s=%b want -2199006478336 1",
               sum, MULTSIGNOUT);
    end
  endtask

  task automatic test_split();
    A_MULT = 25'd1000; B_MULT = 18'd300;
    tick();
    tests++;
    if (sum !== 43'sd300000) begin
      fails++; $display("FAIL split_pos got %0d want 300000", sum);
    end
    A_MULT = -25'sd1000; B_MULT = -18'sd300;
    tick();
    tests++;
    if (sum !== 43'sd300000) begin
      fails++; $display("FAIL split_neg got %0d want 300000", sum);
    end
  endtask

  task automatic test_bypass();
    MREG = 1'b0; CEM = 1'b1; IN_VALID = 1'b1;
    A_MULT = 25'd3; B_MULT = -18'sd5;
    #1;
    tests++;
    if (sum !== -43'sd15 || M_VALID !== 1'b1) begin
      fails++;
      $display("FAIL bypass_comb got %0d v=%b want -15 1", sum, M_VALID);
    end
    tick();
    CEM = 1'b0; IN_VALID = 1'b0;
    A_MULT = 25'd2; B_MULT = 18'd2;
    #1;
    tests++;
    if (sum !== 43'sd4 || M_VALID !== 1'b0) begin
      fails++;
      $display("FAIL bypass_follow got %0d v=%b want 4 0", sum, M_VALID);
    end
    MREG = 1'b1;
    #1;
    tests++;
    if (sum !== -43'sd15 || M_VALID !== 1'b1) begin
      fails++;
      $display("FAIL mreg_switch got %0d v=%b want -15 1", sum, M_VALID);
    end
  endtask

  task automatic test_stall();
    MREG = 1'b1; CEM = 1'b1; IN_VALID = 1'b1;
    A_MULT = 25'd7; B_MULT = 18'd9;
    tick();
    tests++;
    if (sum !== 43'sd63 || M_VALID !== 1'b1) begin
      fails++;
      $display("FAIL stall_load got %0d v=%b want 63 1", sum, M_VALID);
    end
    CEM = 1'b0; IN_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A_MULT = 25'(i + 20); B_MULT = 18'(i + 3);
      tick();
      tests++;
      if (sum !== 43'sd63 || M_VALID !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold%0d got %0d v=%b want 63 1",
                 i, sum, M_VALID);
      end
    end
    CEM = 1'b1; IN_VALID = 1'b1;
    A_MULT = 25'd10; B_MULT = 18'd11;
    tick();
    tests++;
    if (sum !== 43'sd110 || M_VALID !== 1'b1) begin
      fails++;
      $display("FAIL stall_resume got %0d v=%b want 110 1", sum, M_VALID);
    end
  endtask

  task automatic test_reset_mid();
    A_MULT = 25'd5; B_MULT = 18'd5;
    tick();
    rst = 1'b1;
    A_MULT = 25'd6; B_MULT = 18'd6;
    tick();
    tests++;
    if (M_X !== 43'sd0 || M_Y !== 43'sd0 ||
        M_VALID !== 1'b0 || MULTSIGNOUT !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid got %0d/%0d v=%b s=%b want 0/0 0 0",
               M_X, M_Y, M_VALID, MULTSIGNOUT);
    end
    rst = 1'b0;
  endtask

  task automatic test_disable();
    USE_MULT = 1'b0; IN_VALID = 1'b1;
    A_MULT = 25'd100; B_MULT = 18'd100;
    tick();
    tests++;
    if (M_X !== 43'sd0 || M_Y !== 43'sd0 || M_VALID !== 1'b1) begin
      fails++;
      $display("FAIL disable got %0d/%0d v=%b want 0/0 1",
               M_X, M_Y, M_VALID);
    end
    USE_MULT = 1'b1;
    tick();
    tests++;
`ifdef MULT_FUSED_OUT_EN
    if (M_X !== 43'sd10000 || M_Y !== 43'sd0) begin
      fails++;
      $display("FAIL enable got %0d/%0d want 10000/0", M_X, M_Y);
    end
`else
    if (M_X !== 43'sd10000 || M_Y !== 43'sd0 || sum !== 43'sd10000) begin
      fails++;
      $display("FAIL enable got %0d/%0d want 10000/0", M_X, M_Y);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_neg_one();
    test_extremes();
    test_split();
    test_bypass();
    test_stall();
    test_reset_mid();
    test_disable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
